// File: rtl/reloj_pkg.sv
// Shared types for the digital clock button front end: command codes,
// arbiter states and the fixed command priority.
package reloj_pkg;

  typedef enum logic [1:0] {
    CMD_INC        = 2'd0,
    CMD_DEC        = 2'd1,
    CMD_CAMBIAR    = 2'd2,
    CMD_ESTABLECER = 2'd3
  } cmd_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  localparam int NUM_BOTONES = 4;

  // ESTABLECER > CAMBIAR > INC > DEC; caller guarantees at least one bit set.
  function automatic cmd_t elegir_comando(input logic [NUM_BOTONES-1:0] pend);
    cmd_t sel;
    if (pend[CMD_ESTABLECER])   sel = CMD_ESTABLECER;
    else if (pend[CMD_CAMBIAR]) sel = CMD_CAMBIAR;
    else if (pend[CMD_INC])     sel = CMD_INC;
    else                        sel = CMD_DEC;
    return sel;
  endfunction

endpackage

// File: rtl/boton_antirrebote.sv
// One push-button: 2-FF synchroniser, debounce counter and a one-cycle
// press pulse issued the cycle after the debounced state goes pressed.
module boton_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_n_i,
  output logic pulsado_o,
  output logic evento_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, evt_q;
  logic          muestra;

  assign muestra = ~sync2_q;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (muestra == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Flip and restart so a new change needs a full fresh run of samples.
    if (cnt_d == CNT_MAX) begin
      deb_d = muestra;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      sync1_q    <= boton_n_i;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      evt_q      <= deb_q & ~deb_prev_q;
    end
  end

  assign pulsado_o = deb_q;
  assign evento_o  = evt_q;

endmodule

// File: rtl/arbitro_comandos_botones.sv
// Conditions the four clock buttons, auto-repeats inc/dec and serialises
// pending presses into a valid/ready command stream for the edit controller.
module arbitro_comandos_botones
  import reloj_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 6,
  parameter int REPEAT_PERIOD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       incrementar,
  input  logic       decrementar,
  input  logic       cambiar,
  input  logic       establecer,
  input  logic       enable,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       any_held
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_MAX    = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_UNO    = RW'(1);

  logic [NUM_BOTONES-1:0] raw_n, pulsado, evento, eventos;
  logic [NUM_BOTONES-1:0] pend_q, pend_d, clr;
  logic [1:0][RW-1:0]     rep_q, rep_d;
  logic [1:0]             rep_evt;
  logic                   conflicto;
  arb_state_t             state_q, state_d;
  cmd_t                   code_q, code_d;

  assign raw_n = {establecer, cambiar, decrementar, incrementar};

  for (genvar g = 0; g < NUM_BOTONES; g++) begin : g_boton
    boton_antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_boton (
      .clk      (clk),
      .reset    (reset),
      .boton_n_i(raw_n[g]),
      .pulsado_o(pulsado[g]),
      .evento_o (evento[g])
    );
  end

  assign conflicto = pulsado[CMD_INC] & pulsado[CMD_DEC];

  // Repeat counter runs from the press pulse; value REP_MAX marks a repeat.
  always_comb begin
    rep_d   = rep_q;
    rep_evt = '0;
    for (int i = 0; i < 2; i++) begin
      rep_evt[i] = pulsado[i] && !conflicto && (rep_q[i] == REP_MAX);
      if (conflicto || !pulsado[i])  rep_d[i] = '0;
      else if (evento[i])            rep_d[i] = REP_UNO;
      else if (rep_q[i] == REP_MAX)  rep_d[i] = REP_RELOAD;
      else if (rep_q[i] != '0)       rep_d[i] = rep_q[i] + 1'b1;
    end
  end

  assign eventos = evento | {2'b00, rep_evt};

  always_comb begin
    pend_d = eventos | (pend_q & ~clr);
    if (conflicto) pend_d[1:0] = '0;
    if (!enable)   pend_d      = '0;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (enable && (|pend_q)) begin
          code_d  = elegir_comando(pend_q);
          clr     = 4'b0001 << code_d;
          state_d = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (cmd_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      code_q  <= CMD_INC;
      pend_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      rep_q   <= rep_d;
    end
  end

  assign cmd_valid = (state_q == ARB_OFFER);
  assign cmd_code  = code_q;
  assign any_held  = |pulsado;

endmodule

// File: tb/tb_arbitro_comandos_botones.sv
// Directed and random stimulus for the button arbiter, checked every cycle
// against a timestamp/window based reference model of the button rules.
module tb_arbitro_comandos_botones;

  localparam int DEB     = 4;
  localparam int RDELAY  = 6;
  localparam int RPERIOD = 2;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       incrementar = 1'b1;
  logic       decrementar = 1'b1;
  logic       cambiar     = 1'b1;
  logic       establecer  = 1'b1;
  logic       enable      = 1'b1;
  logic       cmd_ready   = 1'b1;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       any_held;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arbitro_comandos_botones #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .incrementar(incrementar),
    .decrementar(decrementar),
    .cambiar    (cambiar),
    .establecer (establecer),
    .enable     (enable),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .any_held   (any_held)
  );

  // Reference model state: raw sample history, debounced level, press timestamps.
  logic [7:0] rh [4];
  logic [3:0] m_deb, m_pend;
  logic [1:0] m_alive, m_code;
  logic       m_off;
  int         t_rise [4];
  int         cyc = 0;

  function automatic int pick(input logic [3:0] p);
    int order [4] = '{3, 2, 0, 1};
    for (int n = 0; n < 4; n++) if (p[order[n]]) return order[n];
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      rh[i]     = 8'hFF;
      t_rise[i] = -1000;
    end
    m_deb   = '0;
    m_pend  = '0;
    m_alive = '0;
    m_code  = '0;
    m_off   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [3:0] raw, deb_prev, req, clr;
    logic       conf, flip;
    int         j, p;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    raw      = {establecer, cambiar, decrementar, incrementar};
    deb_prev = m_deb;
    conf     = deb_prev[0] & deb_prev[1];
    req      = '0;
    clr      = '0;
    // Press becomes pending two edges after the debounced level rises.
    for (int i = 0; i < 4; i++) if (t_rise[i] + 2 == cyc) req[i] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      j = cyc - 2 - t_rise[i];
      if (m_alive[i] && deb_prev[i] && !conf && j >= RDELAY && ((j - RDELAY) % RPERIOD) == 0)
        req[i] = 1'b1;
    end
    if (m_off) begin
      if (cmd_ready) m_off = 1'b0;
    end else if (enable && m_pend != 4'b0) begin
      p        = pick(m_pend);
      m_code   = 2'(p);
      clr[p]   = 1'b1;
      m_off    = 1'b1;
    end
    m_pend = req | (m_pend & ~clr);
    if (conf)    m_pend[1:0] = 2'b00;
    if (!enable) m_pend      = 4'b0;
    for (int i = 0; i < 2; i++) begin
      if (!deb_prev[i] || conf)        m_alive[i] = 1'b0;
      else if (t_rise[i] + 2 == cyc)   m_alive[i] = 1'b1;
    end
    // Debounced level flips once the last DEB synchronised samples all disagree with it.
    for (int i = 0; i < 4; i++) begin
      rh[i] = {rh[i][6:0], raw[i]};
      flip  = 1'b1;
      for (int s = 2; s < 2 + DEB; s++) if (rh[i][s] != m_deb[i]) flip = 1'b0;
      if (flip) begin
        m_deb[i] = ~m_deb[i];
        if (m_deb[i]) t_rise[i] = cyc;
      end
    end
  endfunction

  task automatic check();
    n_cmp++;
    assert (cmd_valid === m_off) else begin
      n_err++;
      $error("FAIL cmd_valid cyc=%0d observed=%b expected=%b", cyc, cmd_valid, m_off);
    end
    n_cmp++;
    assert (cmd_code === m_code) else begin
      n_err++;
      $error("FAIL cmd_code cyc=%0d observed=%0d expected=%0d", cyc, cmd_code, m_code);
    end
    n_cmp++;
    assert (any_held === (|m_deb)) else begin
      n_err++;
      $error("FAIL any_held cyc=%0d observed=%b expected=%b", cyc, any_held, |m_deb);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check();
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check();
    reset = 1'b0;
    tick(5);

    // T1: short inc press (no repeat window reached), then cambiar held 10 cycles
    incrementar = 1'b0; tick(7);
    incrementar = 1'b1; tick(15);
    cambiar = 1'b0;     tick(10);
    cambiar = 1'b1;     tick(15);

    // T2: 3-cycle glitch
    cambiar = 1'b0;     tick(3);
    cambiar = 1'b1;     tick(15);

    // T3: inc held so debounced pressed 20 cycles
    incrementar = 1'b0; tick(20);
    incrementar = 1'b1; tick(25);

    // T4: simultaneous cambiar+establecer with back-pressure
    cmd_ready  = 1'b0;
    cambiar    = 1'b0;
    establecer = 1'b0; tick(14);
    cambiar    = 1'b1;
    establecer = 1'b1;
    cmd_ready  = 1'b1; tick(20);

    // T5: press while disabled, then re-enable
    enable     = 1'b0;
    establecer = 1'b0; tick(12);
    establecer = 1'b1; tick(3);
    enable     = 1'b1; tick(15);

    // T6: inc and dec held together
    incrementar = 1'b0;
    decrementar = 1'b0; tick(25);
    incrementar = 1'b1;
    decrementar = 1'b1; tick(15);

    // Asynchronous reset during an offer
    cmd_ready  = 1'b0;
    establecer = 1'b0; tick(10);
    establecer = 1'b1; tick(1);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    assert (cmd_valid === 1'b0) else begin
      n_err++;
      $error("FAIL async_reset_valid observed=%b expected=0", cmd_valid);
    end
    model_reset();
    tick(2);
    reset     = 1'b0;
    cmd_ready = 1'b1;
    tick(20);

    // Random phase: bouncy and long presses, random enable and back-pressure
    for (int c = 0; c < 1200; c++) begin
      int rate;
      rate = (c < 600) ? 11 : 29;
      if ($urandom_range(rate) == 0) incrementar = ~incrementar;
      if ($urandom_range(rate) == 0) decrementar = ~decrementar;
      if ($urandom_range(rate + 8) == 0) cambiar = ~cambiar;
      if ($urandom_range(rate + 8) == 0) establecer = ~establecer;
      if ($urandom_range(39) == 0) enable = ~enable;
      cmd_ready = ($urandom_range(9) < 7);
      tick(1);
    end

    incrementar = 1'b1;
    decrementar = 1'b1;
    cambiar     = 1'b1;
    establecer  = 1'b1;
    enable      = 1'b1;
    cmd_ready   = 1'b1;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
